// File: rtl/fetch_pkg.sv
// Shared types and sizing helpers for the instruction-fetch unit.
package fetch_pkg;

    // Fetch sequencer states; at most one memory request is ever outstanding.
    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DROP
    } fetch_state_e;

    // Bytes per instruction word, i.e. the sequential PC step.
    function automatic int INSTR_BYTES(input int instr_w);
        return instr_w / 8;
    endfunction

    // Width needed to hold an occupancy count from 0 to depth inclusive.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fetch_prefetch_if.sv
// Memory request/response and decode handshake bundle of the fetch unit.
interface fetch_prefetch_if #(
    parameter int ADDR_W  = 16,
    parameter int INSTR_W = 32
);
    logic               imem_req;
    logic [ADDR_W-1:0]  imem_addr;
    logic               imem_ready;
    logic               imem_rvalid;
    logic [INSTR_W-1:0] imem_rdata;
    logic               ins_valid;
    logic [INSTR_W-1:0] ins;
    logic [ADDR_W-1:0]  ins_pc;
    logic               ins_ready;

    // Fetch unit side.
    modport master (
        output imem_req, imem_addr, ins_valid, ins, ins_pc,
        input  imem_ready, imem_rvalid, imem_rdata, ins_ready
    );

    // Memory/decode side.
    modport slave (
        input  imem_req, imem_addr, ins_valid, ins, ins_pc,
        output imem_ready, imem_rvalid, imem_rdata, ins_ready
    );
endinterface

// File: rtl/fetch_fifo.sv
// Prefetch queue: DEPTH entries of {pc, instruction}, synchronous flush wins
// over push and pop. Head word is read straight from storage so a pushed
// entry is visible the cycle after the push.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int WIDTH = 48,
    parameter int DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          push,
    input  logic                          pop,
    input  logic                          flush,
    input  logic [WIDTH-1:0]              wdata,
    output logic [WIDTH-1:0]              rdata,
    output logic [cnt_width(DEPTH)-1:0]   count,
    output logic                          empty,
    output logic                          full
);
    localparam int CNT_W = cnt_width(DEPTH);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_W'(DEPTH));
    assign count   = count_q;
    assign rdata   = mem_q[rd_ptr_q];
    assign do_pop  = pop && !flush && !empty;
    assign do_push = push && !flush && (!full || do_pop);

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Entry storage; contents need no reset since occupancy gates visibility.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/fetch_prefetch.sv
// Instruction-fetch unit: sequential PC generation, single-outstanding
// memory requests, prefetch queue and branch redirect with stale-response drop.
module fetch_prefetch
    import fetch_pkg::*;
#(
    parameter int              ADDR_W   = 16,
    parameter int              INSTR_W  = 32,
    parameter int              DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              Rst,
    input  logic              En,
    input  logic              branch,
    input  logic [ADDR_W-1:0] br_pc,
    input  logic [ADDR_W-1:0] branoff,
    fetch_prefetch_if.master  bus
);
    localparam int                CNT_W   = cnt_width(DEPTH);
    localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(INSTR_BYTES(INSTR_W));

    fetch_state_e              state_q, state_d;
    logic [ADDR_W-1:0]         fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0]         req_pc_q;
    logic [ADDR_W-1:0]         br_target;
    logic                      accept;
    logic                      push;
    logic                      pop;
    logic                      room_after;
    logic [ADDR_W+INSTR_W-1:0] fifo_rdata;
    logic [CNT_W-1:0]          fifo_count;
    logic                      fifo_empty;
    logic                      fifo_full;

    assign br_target  = br_pc + branoff;
    assign accept     = (state_q == S_REQ) && bus.imem_ready;
    assign pop        = bus.ins_valid && bus.ins_ready;
    assign push       = (state_q == S_WAIT) && bus.imem_rvalid && !branch;
    // Occupancy after this cycle's enqueue (and possible dequeue) leaves a free slot.
    assign room_after = pop || (fifo_count < CNT_W'(DEPTH - 1));

    fetch_fifo #(
        .WIDTH (ADDR_W + INSTR_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (Rst),
        .push  (push),
        .pop   (pop),
        .flush (branch),
        .wdata ({req_pc_q, bus.imem_rdata}),
        .rdata (fifo_rdata),
        .count (fifo_count),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    // State, fetch PC and the PC of the request currently in flight.
    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            state_q    <= S_IDLE;
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= RESET_PC;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            if (accept) req_pc_q <= fetch_pc_q;
        end
    end

    // Next state and next fetch PC; a redirect overrides everything else.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        if (branch)      fetch_pc_d = br_target;
        else if (accept) fetch_pc_d = fetch_pc_q + PC_STEP;
        case (state_q)
            S_IDLE: begin
                if (branch)                          state_d = En ? S_REQ : S_IDLE;
                else if (En && (!fifo_full || pop))  state_d = S_REQ;
            end
            S_REQ: begin
                // An accepted request cannot be recalled, so its response must be dropped.
                if (bus.imem_ready) state_d = branch ? S_DROP : S_WAIT;
                else if (branch)    state_d = En ? S_REQ : S_IDLE;
            end
            S_WAIT: begin
                if (branch)                state_d = bus.imem_rvalid ? (En ? S_REQ : S_IDLE) : S_DROP;
                else if (bus.imem_rvalid)  state_d = (En && room_after) ? S_REQ : S_IDLE;
            end
            S_DROP: begin
                if (bus.imem_rvalid) state_d = En ? S_REQ : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.imem_req  = (state_q == S_REQ);
    assign bus.imem_addr = fetch_pc_q;
    assign bus.ins_valid = !fifo_empty;
    assign bus.ins       = fifo_empty ? '0 : fifo_rdata[INSTR_W-1:0];
    assign bus.ins_pc    = fifo_empty ? '0 : fifo_rdata[ADDR_W+INSTR_W-1:INSTR_W];

endmodule

// File: tb/tb_fetch_prefetch.sv
// Directed scoreboard bench for fetch_prefetch.
module tb_fetch_prefetch;
    localparam int ADDR_W  = 16;
    localparam int INSTR_W = 32;
    localparam int DEPTH   = 4;

    logic        clk;
    logic        Rst;
    logic        En;
    logic        branch;
    logic [15:0] br_pc;
    logic [15:0] branoff;

    fetch_prefetch_if #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) bus_if ();

    fetch_prefetch #(
        .ADDR_W   (ADDR_W),
        .INSTR_W  (INSTR_W),
        .DEPTH    (DEPTH),
        .RESET_PC (16'h0000)
    ) dut (
        .clk     (clk),
        .Rst     (Rst),
        .En      (En),
        .branch  (branch),
        .br_pc   (br_pc),
        .branoff (branoff),
        .bus     (bus_if)
    );

    typedef struct packed {
        logic [15:0] pc;
        logic [31:0] word;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] req_log[$];
    int          checks = 0;
    int          errors = 0;
    int          req_cnt = 0;
    bit          pend = 0;
    bit          hold = 0;
    logic [15:0] pend_addr;

    function automatic logic [31:0] mem_word(input logic [15:0] a);
        return {~a, a};
    endfunction

    function automatic logic [31:0] req_at(input int i);
        if (i < req_log.size()) return 32'(req_log[i]);
        return 32'hDEAD_BEEF;
    endfunction

    task automatic push_exp(input logic [15:0] pc);
        exp_t e;
        e.pc   = pc;
        e.word = mem_word(pc);
        exp_q.push_back(e);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end else begin
            $display("check %s ok: %h", name, act);
        end
    endtask

    // One cycle: note acceptance mid-cycle, then drive the memory response
    // just after the edge. Responses come one cycle after acceptance unless held.
    task automatic tick();
        bit          acc;
        logic [15:0] a;
        @(negedge clk);
        acc = bus_if.imem_req && bus_if.imem_ready && !Rst;
        a   = bus_if.imem_addr;
        if (acc) begin
            req_cnt++;
            req_log.push_back(a);
            $display("req addr=%h", a);
        end
        @(posedge clk);
        #1;
        if (acc) begin
            pend      = 1;
            pend_addr = a;
        end
        bus_if.imem_rvalid = 1'b0;
        bus_if.imem_rdata  = '0;
        if (pend && !hold) begin
            bus_if.imem_rvalid = 1'b1;
            bus_if.imem_rdata  = mem_word(pend_addr);
            pend = 0;
        end
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        bus_if.ins_ready = 1'b1;
        while (exp_q.size() != 0 && n < 200) begin
            tick();
            n++;
        end
        check({name, "_drained"}, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        bus_if.ins_ready = 1'b0;
    endtask

    task automatic do_reset();
        Rst = 1'b1;
        En = 1'b0;
        branch = 1'b0;
        bus_if.ins_ready = 1'b0;
        bus_if.imem_rvalid = 1'b0;
        pend = 0;
        hold = 0;
        tick();
        tick();
        Rst = 1'b0;
        req_cnt = 0;
        req_log.delete();
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Monitor: every accepted head word is compared with the next expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!Rst && bus_if.ins_valid && bus_if.ins_ready && !branch) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_ins: got pc=%h ins=%h, required no output",
                             bus_if.ins_pc, bus_if.ins);
                end else begin
                    e = exp_q.pop_front();
                    if (bus_if.ins_pc !== e.pc || bus_if.ins !== e.word) begin
                        errors++;
                        $display("FAIL ins_out: got pc=%h ins=%h, required pc=%h ins=%h",
                                 bus_if.ins_pc, bus_if.ins, e.pc, e.word);
                    end else begin
                        $display("ins pc=%h ins=%h ok", bus_if.ins_pc, bus_if.ins);
                    end
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        Rst = 1'b1;
        En = 1'b0;
        branch = 1'b0;
        br_pc = '0;
        branoff = '0;
        bus_if.imem_ready = 1'b1;
        bus_if.imem_rvalid = 1'b0;
        bus_if.imem_rdata = '0;
        bus_if.ins_ready = 1'b0;
        tick();
        check("rst_imem_req",  32'(bus_if.imem_req),  32'd0);
        check("rst_imem_addr", 32'(bus_if.imem_addr), 32'h0000);
        check("rst_ins_valid", 32'(bus_if.ins_valid), 32'd0);
        check("rst_ins",       32'(bus_if.ins),       32'd0);
        check("rst_ins_pc",    32'(bus_if.ins_pc),    32'd0);
        Rst = 1'b0;

        // Sequential stream with a free-running consumer.
        for (int i = 0; i < 8; i++) push_exp(16'(i * 4));
        En = 1'b1;
        drain("stream");

        // Backpressure: queue fills after exactly DEPTH requests.
        do_reset();
        En = 1'b1;
        repeat (30) tick();
        check("bp_req_count", 32'(req_cnt), 32'd4);
        check("bp_req_idle",  32'(bus_if.imem_req), 32'd0);
        check("bp_ins_valid", 32'(bus_if.ins_valid), 32'd1);
        req_cnt = 0;
        req_log.delete();
        push_exp(16'h0000);
        bus_if.ins_ready = 1'b1;
        tick();
        bus_if.ins_ready = 1'b0;
        repeat (20) tick();
        check("bp_one_pop",      32'(exp_q.size()), 32'd0);
        check("bp_resume_count", 32'(req_cnt), 32'd1);
        check("bp_resume_addr",  req_at(0), 32'h0010);
        En = 1'b0;
        push_exp(16'h0004);
        push_exp(16'h0008);
        push_exp(16'h000C);
        push_exp(16'h0010);
        drain("bp");
        tick();
        check("bp_empty",    32'(bus_if.ins_valid), 32'd0);
        check("bp_en_gated", 32'(req_cnt), 32'd1);

        // Redirect while a response is pending.
        do_reset();
        En = 1'b1;
        hold = 1;
        tick();
        tick();
        check("w_in_wait", 32'(req_cnt), 32'd1);
        branch = 1'b1;
        br_pc = 16'h0008;
        branoff = 16'h0008;
        req_log.delete();
        tick();
        branch = 1'b0;
        check("w_drop_no_req", 32'(bus_if.imem_req), 32'd0);
        hold = 0;
        repeat (20) tick();
        check("w_first_addr", req_at(0), 32'h0010);
        En = 1'b0;
        push_exp(16'h0010);
        push_exp(16'h0014);
        push_exp(16'h0018);
        push_exp(16'h001C);
        drain("w");

        // Negative offset with address wrap-around.
        do_reset();
        En = 1'b1;
        branch = 1'b1;
        br_pc = 16'h0004;
        branoff = 16'hFFF8;
        tick();
        branch = 1'b0;
        check("wrap_req",  32'(bus_if.imem_req),  32'd1);
        check("wrap_addr", 32'(bus_if.imem_addr), 32'h0000FFFC);
        repeat (20) tick();
        check("wrap_req0", req_at(0), 32'h0000FFFC);
        check("wrap_req1", req_at(1), 32'h00000000);
        En = 1'b0;
        push_exp(16'hFFFC);
        push_exp(16'h0000);
        push_exp(16'h0004);
        push_exp(16'h0008);
        drain("wrap");

        // Branch coincident with rvalid and a dequeue in S_WAIT.
        do_reset();
        En = 1'b1;
        n = 0;
        while (!(bus_if.imem_rvalid && bus_if.ins_valid) && n < 20) begin
            tick();
            n++;
        end
        check("sim_setup", 32'(bus_if.imem_rvalid && bus_if.ins_valid), 32'd1);
        branch = 1'b1;
        br_pc = 16'h0020;
        branoff = 16'h0010;
        bus_if.ins_ready = 1'b1;
        tick();
        branch = 1'b0;
        bus_if.ins_ready = 1'b0;
        En = 1'b0;
        check("sim_ins_valid", 32'(bus_if.ins_valid), 32'd0);
        check("sim_req",       32'(bus_if.imem_req),  32'd1);
        check("sim_addr",      32'(bus_if.imem_addr), 32'h0030);
        push_exp(16'h0030);
        drain("sim");

        // En dropped while waiting: the response still lands, nothing more issues.
        do_reset();
        En = 1'b1;
        hold = 1;
        tick();
        tick();
        En = 1'b0;
        hold = 0;
        repeat (10) tick();
        check("en_req_cnt",   32'(req_cnt), 32'd1);
        check("en_ins_valid", 32'(bus_if.ins_valid), 32'd1);
        push_exp(16'h0000);
        drain("en");

        // Reset while waiting with a non-empty queue; the late response is ignored.
        En = 1'b1;
        n = 0;
        while (!(bus_if.imem_req && bus_if.ins_valid) && n < 20) begin
            tick();
            n++;
        end
        check("rst_setup", 32'(bus_if.imem_req && bus_if.ins_valid), 32'd1);
        hold = 1;
        tick();
        Rst = 1'b1;
        #1;
        check("mid_rst_imem_req",  32'(bus_if.imem_req),  32'd0);
        check("mid_rst_imem_addr", 32'(bus_if.imem_addr), 32'h0000);
        check("mid_rst_ins_valid", 32'(bus_if.ins_valid), 32'd0);
        check("mid_rst_ins",       32'(bus_if.ins),       32'd0);
        check("mid_rst_ins_pc",    32'(bus_if.ins_pc),    32'd0);
        tick();
        Rst = 1'b0;
        En = 1'b0;
        req_cnt = 0;
        hold = 0;
        repeat (5) tick();
        check("stale_ignored", 32'(bus_if.ins_valid), 32'd0);
        check("stale_no_req",  32'(req_cnt), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
